// File: rtl/rtc_shadow_regfile_pkg.sv
// Shared types and constants for the RTC shadow register file.
// Entry names map the chronometer fields onto regfile indices.
package rtc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OPEN   = 2'd1,
    COMMIT = 2'd2,
    DONE   = 2'd3
  } rtc_state_e;

  localparam int unsigned RTC_DW         = 8;
  localparam int unsigned RTC_DEPTH      = 16;
  localparam int unsigned RTC_COMMIT_LEN = 11;
  localparam int unsigned RTC_LIVE_IDX   = 12;

  localparam int unsigned SEC    = 0;
  localparam int unsigned MIN    = 1;
  localparam int unsigned HOUR   = 2;
  localparam int unsigned DAY    = 3;
  localparam int unsigned MON    = 4;
  localparam int unsigned YEAR   = 5;
  localparam int unsigned T_SEC  = 8;
  localparam int unsigned T_MIN  = 9;
  localparam int unsigned T_HOUR = 10;

endpackage

// File: rtl/rtc_shadow_regfile_rdport.sv
// One registered read port: selects the staging word when the entry is
// still pending commit, otherwise the active word; out-of-range reads give 0.
module rtc_regfile_rdport
  import rtc_pkg::*;
#(
  parameter int unsigned DW = RTC_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          addr_ok,
  input  logic          bypass,
  input  logic [DW-1:0] staging_word,
  input  logic [DW-1:0] active_word,
  output logic [DW-1:0] rd_data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (!addr_ok) begin
      rd_data <= '0;
    end else if (bypass) begin
      rd_data <= staging_word;
    end else begin
      rd_data <= active_word;
    end
  end

endmodule

// File: rtl/rtc_shadow_regfile.sv
// Double-buffered RTC register file: staged edits are committed into the
// active bank by a fixed-length scan; one entry is refreshed live every cycle.
//
// state  | meaning
// IDLE   | no session; writes ignored; open starts a session
// OPEN   | edit session; writes land in staging and mark dirty
// COMMIT | scan 0..COMMIT_LEN-1, copying dirty entries into active
// DONE   | commit_done pulse, back to IDLE next cycle
module rtc_shadow_regfile
  import rtc_pkg::*;
#(
  parameter int unsigned DW         = RTC_DW,
  parameter int unsigned DEPTH      = RTC_DEPTH,
  parameter int unsigned AW         = 4,
  parameter int unsigned NRD        = 2,
  parameter int unsigned COMMIT_LEN = RTC_COMMIT_LEN,
  parameter int unsigned LIVE_IDX   = RTC_LIVE_IDX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              open,
  input  logic              abort,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  input  logic [DW-1:0]     live_data,
  output logic              busy,
  output logic              commit_done
);

  rtc_state_e       state;
  logic [DW-1:0]    staging [DEPTH];
  logic [DW-1:0]    active  [DEPTH];
  logic [DEPTH-1:0] dirty;
  logic [AW-1:0]    scan_idx;
  logic             wr_ok;
  logic             in_commit;

  assign wr_ok = wr_en
               && ({1'b0, wr_addr} < (AW+1)'(DEPTH))
               && (wr_addr != AW'(LIVE_IDX));

  assign in_commit = (state == COMMIT) || (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      dirty       <= '0;
      scan_idx    <= '0;
      busy        <= 1'b0;
      commit_done <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        staging[i] <= '0;
        active[i]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (open) begin
            state <= OPEN;
            dirty <= '0;
          end
        end
        OPEN: begin
          if (wr_ok) begin
            staging[wr_addr] <= wr_data;
            dirty[wr_addr]   <= 1'b1;
          end
          // abort wins over a simultaneous close and discards every mark
          if (abort) begin
            state <= IDLE;
            dirty <= '0;
          end else if (!open) begin
            state    <= COMMIT;
            scan_idx <= '0;
            busy     <= 1'b1;
          end
        end
        COMMIT: begin
          if (dirty[scan_idx]) begin
            active[scan_idx] <= staging[scan_idx];
            dirty[scan_idx]  <= 1'b0;
          end
          scan_idx <= scan_idx + 1'b1;
          if (scan_idx == AW'(COMMIT_LEN - 1)) begin
            state       <= DONE;
            commit_done <= 1'b1;
          end
        end
        DONE: begin
          state       <= IDLE;
          busy        <= 1'b0;
          commit_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      // last assignment so the live source overrides any commit of this slot
      active[LIVE_IDX] <= live_data;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          addr_ok;

    assign addr    = rd_addr[k*AW +: AW];
    assign addr_ok = {1'b0, addr} < (AW+1)'(DEPTH);

    rtc_regfile_rdport #(.DW(DW)) u_rdport (
      .clk          (clk),
      .reset        (reset),
      .addr_ok      (addr_ok),
      .bypass       (in_commit && dirty[addr]),
      .staging_word (staging[addr]),
      .active_word  (active[addr]),
      .rd_data      (rd_data[k*DW +: DW])
    );
  end

endmodule

// File: tb/tb_rtc_shadow_regfile.sv
// Scoreboard bench for rtc_shadow_regfile: read expectations are queued when a
// read is issued and compared when the registered data appears.
module tb_rtc_shadow_regfile;
  import rtc_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int NRD   = 2;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              open;
  logic              abort;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [DW-1:0]     live_data;
  logic              busy;
  logic              commit_done;

  always #5 clk = ~clk;

  rtc_shadow_regfile dut (
    .clk         (clk),
    .reset       (reset),
    .open        (open),
    .abort       (abort),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .live_data   (live_data),
    .busy        (busy),
    .commit_done (commit_done)
  );

  typedef struct {
    int            due;
    int            port;
    int            addr;
    logic [DW-1:0] exp;
  } sb_t;

  sb_t           sb[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;
  logic [DW-1:0] mdl [DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    sb_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (rd_data[e.port*DW +: DW] !== e.exp) begin
        errors++;
        $display("FAIL rd_port%0d addr%0d: got %02h expected %02h",
                 e.port, e.addr, rd_data[e.port*DW +: DW], e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int port, input int addr, input logic [DW-1:0] exp);
    sb_t e;
    rd_addr[port*AW +: AW] = AW'(addr);
    e.due  = cyc + 1;
    e.port = port;
    e.addr = addr;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int w = 0;
    while (busy && w < 40) begin
      step();
      w++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout: busy=%b expected 0", name, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; open = 1'b0; abort = 1'b0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0; live_data = '0; rd_addr = '0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    repeat (3) step();
    checks++;
    if (busy !== 1'b0 || commit_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b done=%b expected 0 0", busy, commit_done);
    end
    reset = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      rd(0, a, 8'h00);
      rd(1, DEPTH - 1 - a, 8'h00);
      step();
    end
    step();
  endtask

  task automatic test_commit();
    int busy_cnt = 0, done_cnt = 0, done_at = 0;
    open = 1'b1;
    step();
    wr_en = 1'b1; wr_addr = AW'(MIN); wr_data = 8'h45;
    step();
    // final write shares the cycle where open is sampled low
    wr_addr = AW'(DAY); wr_data = 8'h12; open = 1'b0;
    step();
    wr_en = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (busy) busy_cnt++;
      if (commit_done) begin
        done_cnt++;
        if (done_at == 0) done_at = n;
      end
      step();
    end
    checks++;
    if (busy_cnt != 12) begin
      errors++;
      $display("FAIL commit_busy_len: got %0d expected 12", busy_cnt);
    end
    checks++;
    if (done_at != 12 || done_cnt != 1) begin
      errors++;
      $display("FAIL commit_done_pulse: at %0d count %0d expected at 12 count 1", done_at, done_cnt);
    end
    mdl[MIN] = 8'h45;
    mdl[DAY] = 8'h12;
    rd(0, MIN, mdl[MIN]);
    rd(1, DAY, mdl[DAY]);
    step();
    rd(0, HOUR, mdl[HOUR]);
    rd(1, MIN, mdl[MIN]);
    step();
    step();
  endtask

  task automatic test_abort();
    int seen_busy = 0, seen_done = 0;
    open = 1'b1;
    step();
    wr_en = 1'b1; wr_addr = AW'(SEC); wr_data = 8'h30;
    step();
    wr_en = 1'b0; abort = 1'b1; open = 1'b0;
    step();
    abort = 1'b0;
    for (int n = 0; n < 15; n++) begin
      if (busy) seen_busy++;
      if (commit_done) seen_done++;
      step();
    end
    checks++;
    if (seen_busy != 0 || seen_done != 0) begin
      errors++;
      $display("FAIL abort_no_commit: busy_cycles=%0d done_cycles=%0d expected 0 0", seen_busy, seen_done);
    end
    rd(0, SEC, mdl[SEC]);
    rd(1, SEC, mdl[SEC]);
    step();
    step();
  endtask

  task automatic test_live_and_high();
    live_data = 8'h07;
    open = 1'b1;
    step();
    wr_en = 1'b1; wr_addr = 4'd14; wr_data = 8'hAA;
    step();
    wr_addr = AW'(RTC_LIVE_IDX); wr_data = 8'h55; open = 1'b0;
    step();
    wr_en = 1'b0;
    // entry 14 is pending during the scan even though it will never commit
    rd(0, 14, 8'hAA);
    rd(1, RTC_LIVE_IDX, 8'h07);
    step();
    wait_idle("live_commit");
    rd(0, 14, 8'h00);
    rd(1, RTC_LIVE_IDX, 8'h07);
    step();
    live_data = 8'h3C;
    rd(0, RTC_LIVE_IDX, 8'h07);
    step();
    rd(0, RTC_LIVE_IDX, 8'h3C);
    rd(1, RTC_LIVE_IDX, 8'h3C);
    step();
    step();
  endtask

  task automatic test_commit_bypass();
    open = 1'b1;
    step();
    wr_en = 1'b1; wr_addr = AW'(YEAR); wr_data = 8'h16;
    step();
    wr_en = 1'b0; open = 1'b0;
    step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL bypass_busy: got %b expected 1", busy);
    end
    rd(0, YEAR, 8'h16);
    rd(1, 6, mdl[6]);
    step();
    rd(0, YEAR, 8'h16);
    rd(1, SEC, mdl[SEC]);
    step();
    rd(0, 14, 8'h00);
    rd(1, MIN, mdl[MIN]);
    step();
    wait_idle("bypass_commit");
    mdl[YEAR] = 8'h16;
    rd(0, YEAR, mdl[YEAR]);
    rd(1, SEC, mdl[SEC]);
    step();
    step();
  endtask

  task automatic test_reset_mid_commit();
    int seen_busy = 0, seen_done = 0;
    live_data = 8'h00;
    open = 1'b1;
    step();
    wr_en = 1'b1; wr_addr = AW'(MIN); wr_data = 8'h77;
    step();
    wr_addr = AW'(T_SEC); wr_data = 8'h88;
    step();
    wr_en = 1'b0; open = 1'b0;
    step();
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    for (int n = 0; n < 15; n++) begin
      if (busy) seen_busy++;
      if (commit_done) seen_done++;
      step();
    end
    checks++;
    if (seen_busy != 0 || seen_done != 0) begin
      errors++;
      $display("FAIL midreset_flags: busy_cycles=%0d done_cycles=%0d expected 0 0", seen_busy, seen_done);
    end
    rd(0, MIN, mdl[MIN]);
    rd(1, T_SEC, mdl[T_SEC]);
    step();
    rd(0, DAY, mdl[DAY]);
    rd(1, YEAR, mdl[YEAR]);
    step();
    rd(0, RTC_LIVE_IDX, 8'h00);
    rd(1, SEC, mdl[SEC]);
    step();
    // a fresh empty session must run a full commit from IDLE
    open = 1'b1;
    step();
    open = 1'b0;
    step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_restart: busy=%b expected 1", busy);
    end
    wait_idle("midreset_commit");
    step();
  endtask

  initial begin
    test_reset();
    test_commit();
    test_abort();
    test_live_and_high();
    test_commit_bypass();
    test_reset_mid_commit();
    for (int w = 0; w < 10 && sb.size() > 0; w++) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
